// File: rtl/aes_avalon_regs.sv
// Avalon-MM register file and START/DONE handshake in front of the AES decryption core.
// Define AES_IRQ_EN to add the registered IRQ output (mirrors STATUS.DONE).
module aes_avalon_regs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                AVL_CS,
  input  logic                AVL_READ,
  input  logic                AVL_WRITE,
  input  logic [ADDR_W-1:0]   AVL_ADDR,
  input  logic [DATA_W/8-1:0] AVL_BYTE_EN,
  input  logic [DATA_W-1:0]   AVL_WRITEDATA,
  output logic [DATA_W-1:0]   AVL_READDATA,
  output logic                AES_START,
  input  logic                AES_DONE,
  output logic [127:0]        AES_KEY,
  output logic [127:0]        AES_MSG_ENC,
  input  logic [127:0]        AES_MSG_DEC,
  output logic [31:0]         EXPORT_DATA
`ifdef AES_IRQ_EN
  ,
  output logic                IRQ
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StCapture, StRelease} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] key_q [4];
  logic [DATA_W-1:0] enc_q [4];
  logic [DATA_W-1:0] dec_q [4];
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;

  logic wr_en, rd_en, busy, capture, start_req, w1c_done, data_wr;

  assign wr_en    = AVL_CS & AVL_WRITE;
  assign rd_en    = AVL_CS & AVL_READ;
  assign busy     = (state_q != StIdle);
  assign start_req = wr_en && (AVL_ADDR == ADDR_W'(14)) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  assign w1c_done  = wr_en && (AVL_ADDR == ADDR_W'(15)) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
  // Key/ciphertext writes are dropped while busy so the core sees stable operands.
  assign data_wr   = wr_en && !busy && (AVL_ADDR[3] == 1'b0);

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0]   old_val,
                                                    input logic [DATA_W-1:0]   wdata,
                                                    input logic [DATA_W/8-1:0] be);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q & ~w1c_done;
    capture   = 1'b0;
    AES_START = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        AES_START = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + DATA_W'(1);
        if (AES_DONE) state_d = StCapture;
      end
      StCapture: begin
        capture = 1'b1;
        done_d  = 1'b1;
        state_d = StRelease;
      end
      StRelease: begin
        if (!AES_DONE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    case (AVL_ADDR[3:2])
      2'b00: rdata_d = key_q[AVL_ADDR[1:0]];
      2'b01: rdata_d = enc_q[AVL_ADDR[1:0]];
      2'b10: rdata_d = dec_q[AVL_ADDR[1:0]];
      default: begin
        if (AVL_ADDR[1:0] == 2'd1) rdata_d = cnt_q;
        else if (AVL_ADDR[1:0] == 2'd3) rdata_d = {{(DATA_W-2){1'b0}}, busy, done_q};
        else rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < 4; i++) begin
        key_q[i] <= '0;
        enc_q[i] <= '0;
        dec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      // Mux uses pre-write register values, so read-during-write returns old data.
      if (rd_en) rdata_q <= rdata_d;
      if (data_wr) begin
        if (AVL_ADDR[2] == 1'b0) begin
          key_q[AVL_ADDR[1:0]] <= merge_bytes(key_q[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);
        end else begin
          enc_q[AVL_ADDR[1:0]] <= merge_bytes(enc_q[AVL_ADDR[1:0]], AVL_WRITEDATA, AVL_BYTE_EN);
        end
      end
      if (capture) begin
        for (int i = 0; i < 4; i++) begin
          dec_q[i] <= AES_MSG_DEC[127-32*i -: 32];
        end
      end
    end
  end

`ifdef AES_IRQ_EN
  logic irq_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) irq_q <= 1'b0;
    else          irq_q <= done_d;
  end
  assign IRQ = irq_q;
`endif

  assign AVL_READDATA = rdata_q;
  assign AES_KEY      = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign AES_MSG_ENC  = {enc_q[0], enc_q[1], enc_q[2], enc_q[3]};
  assign EXPORT_DATA  = {key_q[0][31:16], key_q[3][15:0]};

endmodule

// File: tb/tb_aes_avalon_regs.sv
// Directed bench for aes_avalon_regs: register map, byte enables, handshake timing and reset.
// IRQ checks are compiled in only when AES_IRQ_EN is defined.
module tb_aes_avalon_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]   addr = '0;
  logic [3:0]   be = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         start;
  logic         done = 1'b0;
  logic [127:0] key, msg_enc;
  logic [127:0] msg_dec = '0;
  logic [31:0]  export_data;
`ifdef AES_IRQ_EN
  logic         irq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int start_cycles = 0;
  int s0;
  logic [31:0] rv;

  aes_avalon_regs #(.DATA_W(32), .ADDR_W(4)) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .AVL_CS       (cs),
    .AVL_READ     (rd),
    .AVL_WRITE    (wr),
    .AVL_ADDR     (addr),
    .AVL_BYTE_EN  (be),
    .AVL_WRITEDATA(wdata),
    .AVL_READDATA (rdata),
    .AES_START    (start),
    .AES_DONE     (done),
    .AES_KEY      (key),
    .AES_MSG_ENC  (msg_enc),
    .AES_MSG_DEC  (msg_dec),
    .EXPORT_DATA  (export_data)
`ifdef AES_IRQ_EN
    ,
    .IRQ          (irq)
`endif
  );

  always #5 clk = ~clk;

  // Free-running count of cycles with START high; tests take differences.
  always @(negedge clk) if (start) start_cycles <= start_cycles + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
    @(posedge clk);
    #1 cs = 1'b0; wr = 1'b0; be = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk);
    #1 cs = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic check_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_start", start, 1'b0);
    check("rst_key", key, 128'h0);
    check("rst_export", export_data, 32'h0);
    check("rst_readdata", rdata, 32'h0);
`ifdef AES_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif
    for (int i = 0; i < 16; i++) check_read($sformatf("rst_reg%0d", i), 4'(i), 32'h0);

    // Read latency and hold.
    bus_write(4'd1, 32'h1234_5678, 4'hF);
    cs = 1'b1; rd = 1'b1; addr = 4'd1;
    #2 check("rd_latency_pre", rdata, 32'h0);
    @(posedge clk);
    #1 cs = 1'b0; rd = 1'b0;
    check("rd_latency_post", rdata, 32'h1234_5678);
    @(posedge clk);
    #1 check("rd_hold", rdata, 32'h1234_5678);

    // Simultaneous read and write returns old value.
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'd1; wdata = 32'hAAAA_5555; be = 4'hF;
    @(posedge clk);
    #1 cs = 1'b0; rd = 1'b0; wr = 1'b0; be = '0;
    check("rdw_old", rdata, 32'h1234_5678);
    check_read("rdw_new", 4'd1, 32'hAAAA_5555);

    bus_write(4'd2, 32'hDEAD_BEEF, 4'b0101);
    check_read("byte_en", 4'd2, 32'h00AD_00EF);
    check("export_untouched", export_data, 32'h0);

    bus_write(4'd13, 32'hFFFF_FFFF, 4'hF);
    check_read("ro_cnt", 4'd13, 32'h0);
    bus_write(4'd8, 32'hFFFF_FFFF, 4'hF);
    check_read("ro_dec", 4'd8, 32'h0);
    bus_write(4'd14, 32'h1, 4'b1110);
    check("start_needs_be0", start, 1'b0);
    check_read("ctrl_reads0", 4'd14, 32'h0);

    // FIPS-197 key and ciphertext.
    bus_write(4'd0, 32'h0001_0203, 4'hF);
    bus_write(4'd1, 32'h0405_0607, 4'hF);
    bus_write(4'd2, 32'h0809_0A0B, 4'hF);
    bus_write(4'd3, 32'h0C0D_0E0F, 4'hF);
    bus_write(4'd4, 32'h69C4_E0D8, 4'hF);
    bus_write(4'd5, 32'h6A7B_0430, 4'hF);
    bus_write(4'd6, 32'hD8CD_B780, 4'hF);
    bus_write(4'd7, 32'h70B4_C55A, 4'hF);
    check("aes_key", key, 128'h000102030405060708090A0B0C0D0E0F);
    check("aes_msg_enc", msg_enc, 128'h69C4E0D86A7B0430D8CDB78070B4C55A);
    check("export_key", export_data, 32'h0001_0E0F);

    bus_write(4'd14, 32'h1, 4'hF);                  // E0
    s0 = start_cycles;
    check("run_start", start, 1'b1);
    bus_write(4'd0, 32'hFFFF_FFFF, 4'hF);           // E1, dropped
    bus_write(4'd14, 32'h1, 4'hF);                  // E2, ignored
    check_read("run_cnt", 4'd13, 32'd2);            // E3
    check_read("run_status", 4'd15, 32'h2);         // E4
    check_read("run_key_protect", 4'd0, 32'h0001_0203); // E5
    repeat (34) @(posedge clk);                     // E39
    #1 done = 1'b1; msg_dec = 128'h00112233445566778899AABBCCDDEEFF;
    @(posedge clk);                                 // E40 -> capture
    #1 check("capture_start_low", start, 1'b0);
    @(posedge clk);                                 // E41 -> release
    #1 check("start_cycles", start_cycles - s0, 40);
    check("release_start_low", start, 1'b0);
`ifdef AES_IRQ_EN
    check("irq_rise", irq, 1'b1);
`endif
    done = 1'b0;
    @(posedge clk);
    #1;
    check_read("done_status", 4'd15, 32'h1);
    check_read("done_cnt", 4'd13, 32'd40);
    check_read("dec0", 4'd8, 32'h0011_2233);
    check_read("dec1", 4'd9, 32'h4455_6677);
    check_read("dec2", 4'd10, 32'h8899_AABB);
    check_read("dec3", 4'd11, 32'hCCDD_EEFF);

    // DONE in IDLE must not disturb results.
    done = 1'b1; msg_dec = {4{32'hBAD0_BAD0}};
    repeat (2) @(posedge clk);
    #1 done = 1'b0;
    check_read("idle_done_ignored", 4'd8, 32'h0011_2233);

    bus_write(4'd15, 32'h1, 4'hF);
`ifdef AES_IRQ_EN
    check("irq_fall", irq, 1'b0);
`endif
    check_read("w1c_status", 4'd15, 32'h0);

    // Second run: count restarts from 0.
    bus_write(4'd14, 32'h1, 4'hF);                  // E0
    check_read("restart_cnt0", 4'd13, 32'd0);       // E1
    repeat (3) @(posedge clk);                      // E4
    #1 done = 1'b1; msg_dec = 128'h0123456789ABCDEF0011223344556677;
    repeat (2) @(posedge clk);
    #1 done = 1'b0;
    @(posedge clk);
    #1;
    check_read("run2_cnt", 4'd13, 32'd5);
    check_read("run2_dec0", 4'd8, 32'h0123_4567);
    bus_write(4'd0, 32'hCAFE_F00D, 4'hF);
    check_read("idle_write_ok", 4'd0, 32'hCAFE_F00D);

    // Reset mid-run.
    bus_write(4'd14, 32'h1, 4'hF);
    repeat (3) @(posedge clk);
    #1 check("pre_reset_start", start, 1'b1);
    rst_n = 1'b0;
    #1 check("async_start_drop", start, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst2_key", key, 128'h0);
    check("rst2_enc", msg_enc, 128'h0);
    check("rst2_readdata", rdata, 32'h0);
    done = 1'b1; msg_dec = {4{32'h5A5A_5A5A}};
    repeat (3) @(posedge clk);
    #1 done = 1'b0;
    check("rst2_start", start, 1'b0);
    for (int i = 8; i < 12; i++) check_read($sformatf("rst2_dec%0d", i), 4'(i), 32'h0);
    check_read("rst2_status", 4'd15, 32'h0);
    check_read("rst2_cnt", 4'd13, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
